perm_rotate_sched: RTL and testbench
====================================

PERM_ROTATE_SCHED -- requirements
Module: perm_rotate_sched

Interface
REQ-001 Parameter LEN_W, default 8: width of cmd_len; a command covers 1..2^LEN_W beats.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_shift  input  4  initial lane rotation, 0..15.
REQ-007 cmd_step  input  4  rotation increment per accepted beat, mod 16.
REQ-008 cmd_mode  input  1  0 = uniform rotate; 1 = reverse-rotate.
REQ-009 cmd_len  input  LEN_W  beats in command minus one.
REQ-010 in_valid / in_ready  input / output  1 / 1  input beat handshake.
REQ-011 in_data  input  512  16 lanes x 32 bit; lane k = bits [32k+31:32k].
REQ-012 out_valid / out_ready  output / input  1 / 1  output beat handshake.
REQ-013 out_data  output  512  permuted beat, same lane packing.
REQ-014 busy  output  1  high in RUN state.
REQ-015 done  output  1  one-cycle pulse at command completion.

Function
REQ-016 States: IDLE, RUN; IDLE -> RUN on cmd_valid && cmd_ready; RUN -> IDLE on acceptance of the final beat.
REQ-017 cmd_ready SHALL be 1 only in IDLE; on acceptance, shift, step, mode and len are latched and the beat counter is cleared.
REQ-018 in_ready SHALL equal (state == RUN) && (!out_valid || out_ready); in_ready is 0 in IDLE regardless of in_valid.
REQ-019 Per-lane address: mode 0 -> addr_k = shift; mode 1 -> addr_k = (shift - 2k) mod 16; all 4-bit arithmetic wraps mod 16.
REQ-020 Lane k of the permuted beat SHALL be in_data lane ((k + addr_k) mod 16); mode 1 thus yields lane ((shift - k) mod 16), i.e. reversal plus rotation.
REQ-021 Permuted beat is registered into out_data with out_valid set on the cycle after acceptance (latency 1 cycle).
REQ-022 out_data and out_valid SHALL hold stable while out_valid && !out_ready; out_valid clears when out_ready is high and no new beat is accepted that cycle.
REQ-023 A new beat accepted in the same cycle the held beat drains SHALL replace it with out_valid staying 1 (full throughput, one beat per cycle).
REQ-024 On each accepted beat: shift <= (shift + step) mod 16 and beat counter increments; beat index n uses shift = (cmd_shift + n*cmd_step) mod 16.
REQ-025 Final beat is the one accepted when counter == latched len; that cycle the FSM transitions to IDLE.
REQ-026 done SHALL pulse exactly one cycle, in the cycle after the final beat is accepted; busy is low in that cycle.
REQ-027 A new command may be accepted in the first IDLE cycle (same cycle as done); the pending output beat of the previous command is unaffected.
REQ-028 cmd_len = 2^LEN_W - 1 SHALL run 2^LEN_W beats without counter overflow corrupting the termination.
REQ-029 cmd_len = 0 SHALL process exactly one beat.

Reset
REQ-030 On reset: state IDLE, cmd_ready 1, in_ready 0, out_valid 0, out_data 0, busy 0, done 0, shift/step/mode/counter 0.
REQ-031 Reset asserted mid-command SHALL discard the command and any held output beat; no done pulse is issued for it.

Verification
REQ-032 Mode 0, shift 3, step 0, len 0, in lane k = k -> one beat with out lane k = (k+3) mod 16; done 1 cycle later.
REQ-033 Mode 0, shift 15, step 1, len 3 -> beats use shift 15,0,1,2; beat 1 is identity; checks wrap.
REQ-034 Mode 1, shift 0, len 0, lane k = k -> out lane k = (16-k) mod 16, i.e. lanes 0,15,14,...,1.
REQ-035 len 7, out_ready toggling randomly, in_valid gaps -> 8 beats in order, none lost or duplicated, out_data stable while stalled.
REQ-036 Reset pulsed after 2 of 5 beats -> out_valid 0, busy 0, no done; following command (shift 5, len 0) produces correct single beat.
REQ-037 Back-to-back commands with cmd_valid held high -> second accepted in done cycle; continuous out_ready gives no bubble beyond the one IDLE cycle.

Source files
------------

// File: rtl/perm_rotate_sched.sv
// 16-lane x 32-bit beat permuter (uniform or reversed rotation); one-cycle registered output latency.
// The output register stalls under out_ready low; in_ready drops only while a held beat cannot drain.
module perm_rotate_sched #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_shift,
  input  logic [3:0]       cmd_step,
  input  logic             cmd_mode,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [511:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [511:0]     out_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [3:0]       shift_q, step_q;
  logic             mode_q;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic             out_vld_q, done_q;
  logic [511:0]     out_dat_q, perm;
  logic [3:0]       addr, src;
  logic             cmd_acc, beat_acc, last_beat;

  assign cmd_ready = (state_q == IDLE);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign in_ready  = (state_q == RUN) && (!out_vld_q || out_ready);
  assign beat_acc  = in_valid && in_ready;
  // Counter compares against len before incrementing, so len = max never needs a wider counter.
  assign last_beat = beat_acc && (cnt_q == len_q);
  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_acc) state_d = RUN;
      RUN:     if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Mode 1 subtracts 2k so the source lane becomes shift - k: reversal plus rotation.
  always_comb begin
    perm = '0;
    addr = '0;
    src  = '0;
    for (int k = 0; k < 16; k++) begin
      addr = mode_q ? (shift_q - 4'(2 * k)) : shift_q;
      src  = 4'(k) + addr;
      perm[32*k +: 32] = in_data[32*src +: 32];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      step_q  <= '0;
      mode_q  <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else if (cmd_acc) begin
      shift_q <= cmd_shift;
      step_q  <= cmd_step;
      mode_q  <= cmd_mode;
      len_q   <= cmd_len;
      cnt_q   <= '0;
    end else if (beat_acc) begin
      shift_q <= shift_q + step_q;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= last_beat;
      if (beat_acc) begin
        out_vld_q <= 1'b1;
        out_dat_q <= perm;
      end else if (out_ready) begin
        out_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_perm_rotate_sched.sv
// Randomized bench for perm_rotate_sched with a lane-arithmetic reference model and output scoreboard.
module tb_perm_rotate_sched;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_shift = '0, cmd_step = '0;
  logic         cmd_mode = 1'b0;
  logic [7:0]   cmd_len = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [511:0] out_data;
  logic         busy, done;

  int n_cmp = 0, n_err = 0;

  perm_rotate_sched #(.LEN_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_shift(cmd_shift), .cmd_step(cmd_step), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Beat n of a command rotates by shift0 + n*step; lane k takes source (k+s) or (s-k), mod 16.
  function automatic logic [511:0] model_beat(input logic [511:0] d, input int sh0, input int st,
                                              input int md, input int n);
    logic [511:0] r;
    int s, srcl;
    r = '0;
    s = (sh0 + n * st) % 16;
    for (int k = 0; k < 16; k++) begin
      srcl = md ? ((s - k + 16) % 16) : ((k + s) % 16);
      r[32*k +: 32] = d[32*srcl +: 32];
    end
    return r;
  endfunction

  // Reference model state
  logic [511:0] exp_q[$];
  int  m_shift = 0, m_step = 0, m_mode = 0, m_len = 0, m_cnt = 0;
  bit  run_m = 0, done_nxt = 0, stall_prev = 0;
  logic [511:0] hold_data = '0;
  bit  rdy_rand = 0, win = 0, seen = 0;
  int  gap = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      run_m = 0; done_nxt = 0; stall_prev = 0; m_cnt = 0;
    end else begin
      check("done", done, done_nxt);
      check("busy", busy, run_m);
      check("cmd_ready", cmd_ready, !run_m);
      check("in_ready", in_ready, run_m && (!out_valid || out_ready));
      check("out_valid", out_valid, exp_q.size() != 0);
      if (stall_prev) check("stall_data", out_data, hold_data);
      if (win) begin
        if (out_valid) seen = 1;
        else if (seen) gap++;
      end
      done_nxt = 0;
      if (out_valid && out_ready && exp_q.size() != 0)
        check("out_data", out_data, exp_q.pop_front());
      if (in_valid && in_ready) begin
        exp_q.push_back(model_beat(in_data, m_shift, m_step, m_mode, m_cnt));
        if (m_cnt == m_len) begin
          run_m = 0;
          done_nxt = 1;
        end
        m_cnt++;
      end
      if (cmd_valid && cmd_ready) begin
        m_shift = cmd_shift; m_step = cmd_step; m_mode = cmd_mode; m_len = cmd_len;
        m_cnt = 0; run_m = 1;
      end
      stall_prev = out_valid && !out_ready;
      hold_data  = out_data;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_cmd(input int sh, input int st, input int md, input int ln);
    int tmo = 0;
    cmd_valid = 1'b1;
    cmd_shift = 4'(sh); cmd_step = 4'(st); cmd_mode = 1'(md); cmd_len = 8'(ln);
    @(negedge clk);
    while (!cmd_ready && tmo < 100) begin tmo++; @(negedge clk); end
    if (tmo >= 100) check("cmd_tmo", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input int n, input bit gaps, input bit ramp);
    for (int i = 0; i < n; i++) begin
      int tmo = 0;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      for (int k = 0; k < 16; k++) in_data[32*k +: 32] = ramp ? 32'(k) : $urandom;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && tmo < 200) begin tmo++; @(negedge clk); end
      if (tmo >= 200) check("in_tmo", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int tmo = 0;
    @(negedge clk);
    while ((out_valid || exp_q.size() != 0) && tmo < 200) begin tmo++; @(negedge clk); end
    if (tmo >= 200) check("drain_tmo", out_valid, 0);
    @(posedge clk); #1;
  endtask

  logic [511:0] e;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, '0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Plain rotate by 3, single beat
    send_cmd(3, 0, 0, 0);
    send_beats(1, 0, 1);
    @(negedge clk);
    for (int k = 0; k < 16; k++) e[32*k +: 32] = 32'((k + 3) % 16);
    check("rot3_data", out_data, e);
    check("rot3_done", done, 1);
    wait_drain();

    // Reverse rotate, shift 0: lanes 0,15,14,...,1
    send_cmd(0, 0, 1, 0);
    send_beats(1, 0, 1);
    @(negedge clk);
    for (int k = 0; k < 16; k++) e[32*k +: 32] = 32'((16 - k) % 16);
    check("rev0_data", out_data, e);
    wait_drain();

    // Shift wraps 15 -> 0 -> 1 -> 2
    send_cmd(15, 1, 0, 3);
    send_beats(4, 0, 0);
    wait_drain();

    // Backpressure and input gaps
    rdy_rand = 1;
    send_cmd($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), 7);
    send_beats(8, 1, 0);
    wait_drain();
    for (int c = 0; c < 6; c++) begin
      int ln = $urandom_range(0, 15);
      send_cmd($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), ln);
      send_beats(ln + 1, 1, 0);
      wait_drain();
    end
    rdy_rand = 0;
    wait_drain();

    // Reset mid-command after 2 of 5 beats
    send_cmd(7, 2, 1, 4);
    send_beats(2, 0, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(posedge clk); #1 reset = 1'b0;
    send_cmd(5, 0, 0, 0);
    send_beats(1, 0, 0);
    wait_drain();

    // Back-to-back commands with cmd_valid held high
    cmd_valid = 1'b1;
    cmd_shift = 4'd2; cmd_step = 4'd3; cmd_mode = 1'b0; cmd_len = 8'd2;
    @(negedge clk);
    @(posedge clk); #1;
    cmd_shift = 4'd9; cmd_step = 4'd5; cmd_mode = 1'b1; cmd_len = 8'd1;
    win = 1; seen = 0; gap = 0;
    send_beats(3, 0, 0);
    @(negedge clk);
    check("b2b_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    send_beats(2, 0, 0);
    win = 0;
    check("b2b_gap", 512'(gap), 512'(1));
    wait_drain();

    // Maximum length: 256 beats
    send_cmd($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), 255);
    send_beats(256, 0, 0);
    wait_drain();
    check("max_busy", busy, 0);
    check("sb_empty", 512'(exp_q.size()), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
